// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: ALU opcodes and execute->memory buffer entry shared across the pipeline
package simplerisc_pkg;
  localparam int XLEN = 32;
  localparam int REG_W = 4;
  typedef enum logic [4:0] {
    ALU_ADD = 5'b00000, ALU_SUB = 5'b00001, ALU_MUL = 5'b00010, ALU_DIV = 5'b00011,
    ALU_MOD = 5'b00100, ALU_CMP = 5'b00101, ALU_AND = 5'b00110, ALU_OR  = 5'b00111,
    ALU_NOT = 5'b01000, ALU_LSL = 5'b01001, ALU_LSR = 5'b01010, ALU_ASR = 5'b01011
  } alu_op_e;
  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic [REG_W-1:0] rd;
    logic is_ld;
    logic is_st;
    logic is_wb;
  } entry_t;
endpackage

// File: rtl/ex_ma_stage_if.sv
// ex_ma_stage_if: execute->memory handshake plus flag and redirect outputs
interface ex_ma_stage_if #(parameter int DATA_W = 32, parameter int RD_W = 4);
  logic in_valid, in_ready, flush, out_valid, out_ready;
  logic [4:0] in_alu_control;
  logic [DATA_W-1:0] in_a, in_b, in_result, in_store_data, in_target;
  logic [RD_W-1:0] in_rd, out_rd;
  logic in_is_ld, in_is_st, in_is_wb, in_is_beq, in_is_bgt, in_is_b;
  logic [DATA_W-1:0] out_result, out_store_data, branch_pc;
  logic out_is_ld, out_is_st, out_is_wb, flags_e, flags_gt, branch_taken;
  modport master (
    output in_valid, in_alu_control, in_a, in_b, in_result, in_store_data, in_rd,
           in_is_ld, in_is_st, in_is_wb, in_is_beq, in_is_bgt, in_is_b, in_target, flush, out_ready,
    input  in_ready, out_valid, out_result, out_store_data, out_rd, out_is_ld, out_is_st, out_is_wb,
           flags_e, flags_gt, branch_taken, branch_pc
  );
  modport slave (
    input  in_valid, in_alu_control, in_a, in_b, in_result, in_store_data, in_rd,
           in_is_ld, in_is_st, in_is_wb, in_is_beq, in_is_bgt, in_is_b, in_target, flush, out_ready,
    output in_ready, out_valid, out_result, out_store_data, out_rd, out_is_ld, out_is_st, out_is_wb,
           flags_e, flags_gt, branch_taken, branch_pc
  );
endinterface

// File: rtl/ex_ma_skid_buf.sv
// ex_ma_skid_buf: 2-entry in-order buffer, head in slot 0, ready registered from next count
module ex_ma_skid_buf import simplerisc_pkg::*; (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   in_valid_i,
  input  logic   flush_i,
  input  entry_t din_i,
  output logic   in_ready_o,
  output logic   out_valid_o,
  input  logic   out_ready_i,
  output entry_t dout_o
);
  entry_t mem_q [2];
  entry_t mem_d [2];
  logic [1:0] cnt_q, cnt_d;
  logic rdy_q, push, pop, wr;
  assign push = in_valid_i && rdy_q;
  assign pop = out_valid_o && out_ready_i;
  // write slot is the first free one after the head shift
  assign wr = cnt_q[0] ^ pop;
  always_comb begin
    mem_d = mem_q;
    if (pop) mem_d[0] = mem_q[1];
    if (push) mem_d[wr] = din_i;
    cnt_d = flush_i ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= 2'd0;
      rdy_q <= 1'b0;
      mem_q <= '{'0, '0};
    end else begin
      cnt_q <= cnt_d;
      rdy_q <= ~cnt_d[1];
      mem_q <= mem_d;
    end
  end
  assign in_ready_o = rdy_q;
  assign out_valid_o = |cnt_q;
  assign dout_o = mem_q[0];
endmodule

// File: rtl/ex_ma_stage.sv
// ex_ma_stage: execute/memory pipeline buffer with compare-flag update and branch resolution
module ex_ma_stage import simplerisc_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int RD_W = 4
) (
  input logic clk,
  input logic rst_n,
  ex_ma_stage_if.slave bus
);
  entry_t ent, head;
  logic push, cmp, taken, fe_d, fe_q, fg_d, fg_q, bt_d, bt_q;
  logic [DATA_W-1:0] bpc_d, bpc_q;
  assign ent = '{result: XLEN'(bus.in_result), store_data: XLEN'(bus.in_store_data),
                 rd: REG_W'(bus.in_rd), is_ld: bus.in_is_ld, is_st: bus.in_is_st, is_wb: bus.in_is_wb};
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  // branches see flags as registered before this edge, so a cmp one cycle earlier is visible
  always_comb begin
    cmp = push && (bus.in_alu_control == ALU_CMP);
    taken = bus.in_is_b || (bus.in_is_beq && fe_q) || (bus.in_is_bgt && fg_q);
    fe_d = cmp ? (bus.in_a == bus.in_b) : fe_q;
    fg_d = cmp ? ($signed(bus.in_a) > $signed(bus.in_b)) : fg_q;
    bt_d = push && taken;
    bpc_d = bt_d ? bus.in_target : bpc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fe_q <= 1'b0;
      fg_q <= 1'b0;
      bt_q <= 1'b0;
      bpc_q <= '0;
    end else begin
      fe_q <= fe_d;
      fg_q <= fg_d;
      bt_q <= bt_d;
      bpc_q <= bpc_d;
    end
  end
  ex_ma_skid_buf u_buf (
    .clk(clk), .rst_n(rst_n), .in_valid_i(bus.in_valid), .flush_i(bus.flush), .din_i(ent),
    .in_ready_o(bus.in_ready), .out_valid_o(bus.out_valid), .out_ready_i(bus.out_ready), .dout_o(head)
  );
  assign bus.out_result = DATA_W'(head.result);
  assign bus.out_store_data = DATA_W'(head.store_data);
  assign bus.out_rd = RD_W'(head.rd);
  assign bus.out_is_ld = head.is_ld;
  assign bus.out_is_st = head.is_st;
  assign bus.out_is_wb = head.is_wb;
  assign bus.flags_e = fe_q;
  assign bus.flags_gt = fg_q;
  assign bus.branch_taken = bt_q;
  assign bus.branch_pc = bpc_q;
endmodule
